chacha_column: RTL

- One column of a ChaCha block core: holds words a/b/c/d of one state column, with init copies of b/c/d.
- Unlike the externally stepped quarter unit, it runs its own step/round sequencer: load, R rounds with inter-column row shifts, add-back and optional counter increment.
- Four instances (COL=0..3) run in lockstep off a shared start pulse, with neighbouring shift buses tied together; the byte bus is shared for load and readout.

---
 rtl/chacha_pkg.sv | 41 ++++
 rtl/chacha_qr_step.sv | 25 ++
 rtl/chacha_column.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types and constants for the ChaCha column core
package chacha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_SHIFT,
        ST_ADD,
        ST_DONE
    } state_t;

    localparam int ROT1_DEF = 16;
    localparam int ROT2_DEF = 12;
    localparam int ROT3_DEF = 8;
    localparam int ROT4_DEF = 7;

    // "expand 32-byte k" as little-endian words, one per column
    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    // byte-bus address fields: [5:4] row, [3:2] column, [1:0] byte
    localparam int ROW_HI  = 5;
    localparam int ROW_LO  = 4;
    localparam int COL_HI  = 3;
    localparam int COL_LO  = 2;
    localparam int BYTE_HI = 1;
    localparam int BYTE_LO = 0;

    function automatic logic [31:0] set_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  val);
        logic [31:0] res;
        res = word;
        res[{idx, 3'b000} +: 8] = val;
        return res;
    endfunction

endpackage

// File: rtl/chacha_qr_step.sv
// rtl/chacha_qr_step.sv - one quarter-round half step: x+y and rotl(z^(x+y))
module chacha_qr_step #(
    parameter int ROT_A = 16,
    parameter int ROT_B = 8
) (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic        sel_b,
    output logic [31:0] sum,
    output logic [31:0] mix
);

    logic [31:0] t;
    logic [31:0] rot_a;
    logic [31:0] rot_b;

    assign sum   = x + y;
    assign t     = z ^ sum;
    assign rot_a = (t << ROT_A) | (t >> (32 - ROT_A));
    assign rot_b = (t << ROT_B) | (t >> (32 - ROT_B));
    // the first and second pass of a round use different rotation amounts
    assign mix   = sel_b ? rot_b : rot_a;

endmodule

// File: rtl/chacha_column.sv
// rtl/chacha_column.sv - one self-sequenced column of a ChaCha block core
module chacha_column
    import chacha_pkg::*;
#(
    parameter int          COL       = 0,
    parameter logic [31:0] A_INIT    = 32'h0,
    parameter int          ROUNDS    = 20,
    parameter int          ROT1      = ROT1_DEF,
    parameter int          ROT2      = ROT2_DEF,
    parameter int          ROT3      = ROT3_DEF,
    parameter int          ROT4      = ROT4_DEF,
    parameter int          CTR_WORDS = 1,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write,
    input  logic [5:0]  addr_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [95:0] shift_out,
    input  logic [95:0] shift_in,
    input  logic        ctr_in,
    output logic        ctr_out
);

    localparam logic [1:0] COL_ID     = 2'(COL);
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);
    localparam bit         CTR_LO     = AUTO_INC && (COL == 0);
    localparam bit         CTR_HI     = AUTO_INC && (COL == 1) && (CTR_WORDS == 2);

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [4:0]  round;
    logic [31:0] a, b, c, d;
    logic [31:0] b_init, c_init, d_init;
    logic [31:0] sum_ab, mix_d, sum_cd, mix_b;
    logic [31:0] row_word;
    logic        col_hit;
    logic        wr_hit;

    chacha_qr_step #(.ROT_A(ROT1), .ROT_B(ROT3)) u_qr_ad (
        .x(a), .y(b), .z(d), .sel_b(step[1]), .sum(sum_ab), .mix(mix_d)
    );

    chacha_qr_step #(.ROT_A(ROT2), .ROT_B(ROT4)) u_qr_cb (
        .x(c), .y(d), .z(b), .sel_b(step[1]), .sum(sum_cd), .mix(mix_b)
    );

    assign col_hit   = (addr_in[COL_HI:COL_LO] == COL_ID);
    assign wr_hit    = write && (state == ST_IDLE) && col_hit && (addr_in[ROW_HI:ROW_LO] != 2'd0);
    assign shift_out = {d, c, b};
    assign ctr_out   = (COL == 0) ? (d_init == 32'hFFFF_FFFF) : 1'b0;

    // next-state sequencing: load, CALC/SHIFT per round, add-back, done
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_CALC;
            ST_CALC:  if (step == 2'd3) state_nxt = ST_SHIFT;
            ST_SHIFT: if (step == 2'd2) state_nxt = (round == LAST_ROUND) ? ST_ADD : ST_CALC;
            ST_ADD:   state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // state register with registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_LOAD) || (state_nxt == ST_CALC) ||
                     (state_nxt == ST_SHIFT) || (state_nxt == ST_ADD);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // step/sub counter restarts on every state change; round counts completed SHIFTs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= 2'd0;
            round <= 5'd0;
        end else begin
            step <= (state_nxt != state) ? 2'd0 : step + 2'd1;
            if (state == ST_LOAD)
                round <= 5'd0;
            else if (state == ST_SHIFT && step == 2'd2)
                round <= round + 5'd1;
        end
    end

    // working words, init copies and counter update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a      <= A_INIT;
            b      <= 32'h0;
            c      <= 32'h0;
            d      <= 32'h0;
            b_init <= 32'h0;
            c_init <= 32'h0;
            d_init <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_hit) begin
                        case (addr_in[ROW_HI:ROW_LO])
                            2'd1: begin
                                b      <= set_byte(b, addr_in[BYTE_HI:BYTE_LO], data_in);
                                b_init <= set_byte(b_init, addr_in[BYTE_HI:BYTE_LO], data_in);
                            end
                            2'd2: begin
                                c      <= set_byte(c, addr_in[BYTE_HI:BYTE_LO], data_in);
                                c_init <= set_byte(c_init, addr_in[BYTE_HI:BYTE_LO], data_in);
                            end
                            default: begin
                                d      <= set_byte(d, addr_in[BYTE_HI:BYTE_LO], data_in);
                                d_init <= set_byte(d_init, addr_in[BYTE_HI:BYTE_LO], data_in);
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    a <= A_INIT;
                    b <= b_init;
                    c <= c_init;
                    d <= d_init;
                end
                ST_CALC: begin
                    if (!step[0]) begin
                        a <= sum_ab;
                        d <= mix_d;
                    end else begin
                        c <= sum_cd;
                        b <= mix_b;
                    end
                end
                ST_SHIFT: begin
                    // even round rotates rows into diagonals, odd round rotates them back
                    if (step == 2'd0 || round[0])  b <= shift_in[31:0];
                    if (step != 2'd2)              c <= shift_in[63:32];
                    if (step == 2'd0 || !round[0]) d <= shift_in[95:64];
                end
                ST_ADD: begin
                    a <= a + A_INIT;
                    b <= b + b_init;
                    c <= c + c_init;
                    d <= d + d_init;
                    if (CTR_LO) d_init <= d_init + 32'd1;
                    if (CTR_HI) d_init <= d_init + {31'b0, ctr_in};
                end
                default: ;
            endcase
        end
    end

    // byte readout of the addressed row of this column
    always_comb begin
        row_word = a;
        case (addr_in[ROW_HI:ROW_LO])
            2'd0:    row_word = a;
            2'd1:    row_word = b;
            2'd2:    row_word = c;
            default: row_word = d;
        endcase
        data_out = 8'h00;
        if (col_hit) data_out = row_word[{addr_in[BYTE_HI:BYTE_LO], 3'b000} +: 8];
    end

endmodule
